// File: rtl/cu_state_register.sv
// cu_state_register: control-unit state register for the multicycle CPU.
// Registers the next-state code, rejects illegal codes, bounds memory wait
// states with a MOC timeout and decodes the current state into control lines.
module cu_state_register #(
    parameter int STATE_W    = 7,
    parameter int WAIT_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] next_s,
    input  logic               moc,
    input  logic               hold,
    output logic [STATE_W-1:0] current_s,
    output logic               ld_mar,
    output logic               ld_mdr,
    output logic               ld_ir,
    output logic               ld_pc,
    output logic               ld_rf,
    output logic               mfa,
    output logic               rw,
    output logic [3:0]         alu_op,
    output logic               alu_from_ir,
    output logic               mem_timeout,
    output logic               illegal_state
);

    localparam logic [STATE_W-1:0] S_0  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_1  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_2  = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_3  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_4  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_5  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_6  = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_7  = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_8  = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_33 = STATE_W'(33);
    localparam logic [STATE_W-1:0] S_34 = STATE_W'(34);
    localparam logic [STATE_W-1:0] S_35 = STATE_W'(35);
    localparam logic [STATE_W-1:0] S_36 = STATE_W'(36);
    localparam logic [STATE_W-1:0] S_37 = STATE_W'(37);
    localparam logic [STATE_W-1:0] S_39 = STATE_W'(39);
    localparam logic [STATE_W-1:0] S_40 = STATE_W'(40);
    localparam logic [STATE_W-1:0] S_44 = STATE_W'(44);
    localparam logic [STATE_W-1:0] S_46 = STATE_W'(46);
    localparam logic [STATE_W-1:0] S_47 = STATE_W'(47);
    localparam logic [STATE_W-1:0] S_49 = STATE_W'(49);

    // Counter value at which the next stalled edge is the WAIT_LIMIT-th one.
    localparam logic [7:0] CNT_LAST = 8'(WAIT_LIMIT - 1);

    logic [STATE_W-1:0] current_q, current_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic               illegal_q, illegal_d;
    logic               rw_flag_q, rw_flag_d;

    logic in_wait;
    logic stalled;
    logic timeout_fire;
    logic next_legal;

    assign in_wait      = (current_q == S_3) || (current_q == S_35);
    assign stalled      = in_wait && !moc;
    assign timeout_fire = stalled && (wait_cnt_q == CNT_LAST);

    // Membership test for the set of state codes the encoder may produce.
    always_comb begin
        next_legal = 1'b0;
        case (next_s)
            S_0, S_1, S_2, S_3, S_4, S_5, S_6, S_7, S_8,
            S_33, S_34, S_35, S_36, S_37, S_39, S_40,
            S_44, S_46, S_47, S_49: next_legal = 1'b1;
            default:                next_legal = 1'b0;
        endcase
    end

    // Next-state selection: hold freezes, then timeout, then illegal filter, then load.
    always_comb begin
        current_d     = current_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        illegal_d     = 1'b0;
        rw_flag_d     = rw_flag_q;
        if (!hold) begin
            // Remember the direction of the access that leads into state 35.
            if (current_q == S_34) rw_flag_d = 1'b1;
            if (current_q == S_44) rw_flag_d = 1'b0;
            wait_cnt_d = stalled ? (wait_cnt_q + 8'd1) : 8'd0;
            if (timeout_fire) begin
                current_d     = S_0;
                mem_timeout_d = 1'b1;
                wait_cnt_d    = 8'd0;
            end else if (!next_legal) begin
                current_d = S_0;
                illegal_d = 1'b1;
            end else begin
                current_d = next_s;
            end
        end
    end

    // State and bookkeeping registers; reset aborts any wait immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_q     <= S_0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            illegal_q     <= 1'b0;
            rw_flag_q     <= 1'b1;
        end else begin
            current_q     <= current_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            illegal_q     <= illegal_d;
            rw_flag_q     <= rw_flag_d;
        end
    end

    // Control word decode from the registered state (moc gates the wait-state loads).
    always_comb begin
        ld_mar      = 1'b0;
        ld_mdr      = 1'b0;
        ld_ir       = 1'b0;
        ld_pc       = 1'b0;
        ld_rf       = 1'b0;
        mfa         = 1'b0;
        rw          = 1'b1;
        alu_op      = 4'b0000;
        alu_from_ir = 1'b0;
        case (current_q)
            S_0:        begin ld_mar = 1'b1; alu_op = 4'b1101; end
            S_1, S_7:   begin ld_pc  = 1'b1; alu_op = 4'b0100; end
            S_2, S_34:  begin mfa    = 1'b1; end
            S_3:        begin mfa    = 1'b1; ld_ir = moc; end
            S_5, S_6:   begin ld_rf  = 1'b1; alu_from_ir = 1'b1; end
            S_8:        begin ld_rf  = 1'b1; alu_op = 4'b1101; end
            S_33, S_47: begin ld_mar = 1'b1; alu_op = 4'b0100; end
            S_37, S_46: begin ld_mar = 1'b1; alu_op = 4'b0010; end
            S_40:       begin ld_mar = 1'b1; alu_op = 4'b1101; end
            S_44:       begin mfa    = 1'b1; rw = 1'b0; ld_mdr = 1'b1; end
            S_35:       begin mfa    = 1'b1; rw = rw_flag_q; ld_mdr = moc; end
            S_36:       begin ld_rf  = 1'b1; end
            S_39:       begin ld_rf  = 1'b1; alu_op = 4'b0100; end
            S_49:       begin ld_rf  = 1'b1; alu_op = 4'b0010; end
            default:    begin end
        endcase
    end

    assign current_s     = current_q;
    assign mem_timeout   = mem_timeout_q;
    assign illegal_state = illegal_q;

endmodule
